// File: rtl/nrow_game_engine.sv
// nrow_game_engine: BOARD_N x BOARD_N n-in-a-row game engine.
// Holds the board, arbitrates player turns, validates moves and scans the
// four lines through the last move (one direction per cycle) for WIN_K in a row.
// Optional single-level undo is compiled in when TTT_UNDO_EN is defined.
// Ports:
//   clk, reset (async, active-low), new_game (sync clear)
//   move_valid/move_player/move_row/move_col : move request
//   undo         : undo last move (TTT_UNDO_EN builds only)
//   move_ready   : engine idle, can accept a move
//   move_ack     : one-cycle pulse, move accepted
//   move_illegal : one-cycle pulse, move rejected
//   turn         : player expected next (0 = P1)
//   game_over, winner (00 none, 01 P1, 10 P2), draw
//   board        : 2 bits per cell, cell index = row*BOARD_N+col, cell 0 in LSBs
module nrow_game_engine #(
  parameter int BOARD_N = 3,
  parameter int WIN_K   = 3,
  localparam int CW     = $clog2(BOARD_N)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_game,
  input  logic                           move_valid,
  input  logic                           move_player,
  input  logic [CW-1:0]                  move_row,
  input  logic [CW-1:0]                  move_col,
  input  logic                           undo,
  output logic                           move_ready,
  output logic                           move_ack,
  output logic                           move_illegal,
  output logic                           turn,
  output logic                           game_over,
  output logic [1:0]                     winner,
  output logic                           draw,
  output logic [2*BOARD_N*BOARD_N-1:0]   board
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int MW    = $clog2(CELLS + 1);
  // Index width has headroom so out-of-range coordinates never wrap onto a real cell.
  localparam int IW    = $clog2(CELLS) + 2;
  // Signed scan coordinates: range -(WIN_K-1) .. 2*BOARD_N-2.
  localparam int SW    = CW + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW:0]          NU = (CW+1)'(BOARD_N);
  localparam logic signed [SW-1:0] NS = SW'(BOARD_N);
  localparam logic signed [SW-1:0] ZS = '0;

  logic [1:0]    state;
  logic [1:0]    dir;
  logic [MW-1:0] move_count;
  logic [CW-1:0] last_row;
  logic [CW-1:0] last_col;
  logic          last_player;

`ifdef TTT_UNDO_EN
  logic          undoable;
`else
  logic          unused_undo;
  assign unused_undo = undo;
`endif

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return IW'(r) * IW'(BOARD_N) + IW'(c);
  endfunction

  function automatic logic in_board(input logic signed [SW-1:0] r, input logic signed [SW-1:0] c);
    return (r >= ZS) && (r < NS) && (c >= ZS) && (c < NS);
  endfunction

  assign move_ready = (state == IDLE);
  assign game_over  = (state == DONE);

  logic       legal;
  logic [1:0] target;
  assign target = board[2*cell_idx(move_row, move_col) +: 2];
  assign legal  = ({1'b0, move_row} < NU) && ({1'b0, move_col} < NU) &&
                  (move_player == turn) && (target == 2'b00);

  // Run length through the last move along direction dir, each side capped at WIN_K-1.
  logic signed [SW-1:0] fr, fc, br, bc, dr, dc;
  logic                 f_alive, b_alive;
  logic [5:0]           run;
  logic [1:0]           lp_code;
  logic                 win_hit;

  always_comb begin
    lp_code = last_player ? 2'b10 : 2'b01;
    case (dir)
      2'd0:    begin dr = '0;        dc = SW'(1); end
      2'd1:    begin dr = SW'(1);    dc = '0;     end
      2'd2:    begin dr = SW'(1);    dc = SW'(1); end
      default: begin dr = SW'(1);    dc = '1;     end
    endcase
    fr = {2'b00, last_row};
    fc = {2'b00, last_col};
    br = fr;
    bc = fc;
    f_alive = 1'b1;
    b_alive = 1'b1;
    run = 6'd1;
    for (int unsigned i = 1; i < WIN_K; i++) begin
      fr = fr + dr;
      fc = fc + dc;
      if (f_alive && in_board(fr, fc) &&
          board[2*cell_idx(fr[CW-1:0], fc[CW-1:0]) +: 2] == lp_code)
        run = run + 6'd1;
      else
        f_alive = 1'b0;
      br = br - dr;
      bc = bc - dc;
      if (b_alive && in_board(br, bc) &&
          board[2*cell_idx(br[CW-1:0], bc[CW-1:0]) +: 2] == lp_code)
        run = run + 6'd1;
      else
        b_alive = 1'b0;
    end
    win_hit = (run >= 6'(WIN_K));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      dir          <= '0;
      move_count   <= '0;
      last_row     <= '0;
      last_col     <= '0;
      last_player  <= 1'b0;
      board        <= '0;
      turn         <= 1'b0;
      move_ack     <= 1'b0;
      move_illegal <= 1'b0;
      winner       <= 2'b00;
      draw         <= 1'b0;
`ifdef TTT_UNDO_EN
      undoable     <= 1'b0;
`endif
    end else if (new_game) begin
      state        <= IDLE;
      dir          <= '0;
      move_count   <= '0;
      last_row     <= '0;
      last_col     <= '0;
      last_player  <= 1'b0;
      board        <= '0;
      turn         <= 1'b0;
      move_ack     <= 1'b0;
      move_illegal <= 1'b0;
      winner       <= 2'b00;
      draw         <= 1'b0;
`ifdef TTT_UNDO_EN
      undoable     <= 1'b0;
`endif
    end else begin
      move_ack     <= 1'b0;
      move_illegal <= 1'b0;
      case (state)
        IDLE: begin
`ifdef TTT_UNDO_EN
          // Undo takes priority; a coincident move is dropped silently.
          if (undo && undoable) begin
            board[2*cell_idx(last_row, last_col) +: 2] <= 2'b00;
            move_count <= move_count - 1'b1;
            turn       <= last_player;
            undoable   <= 1'b0;
          end else
`endif
          if (move_valid) begin
            if (legal) begin
              board[2*cell_idx(move_row, move_col) +: 2] <= move_player ? 2'b10 : 2'b01;
              move_count  <= move_count + 1'b1;
              last_row    <= move_row;
              last_col    <= move_col;
              last_player <= move_player;
              move_ack    <= 1'b1;
              dir         <= '0;
              state       <= CHECK;
            end else begin
              move_illegal <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (win_hit) begin
            winner <= last_player ? 2'b10 : 2'b01;
            state  <= DONE;
          end else if (dir != 2'd3) begin
            dir <= dir + 2'd1;
          end else if (move_count == MW'(CELLS)) begin
            draw  <= 1'b1;
            state <= DONE;
          end else begin
            turn  <= ~turn;
            state <= IDLE;
`ifdef TTT_UNDO_EN
            undoable <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
